vga_timing_ce: RTL
==================

// Module: vga_timing_ce
// PURPOSE
//  640x480@60 VGA timing generator. Runs on clk_100MHz and uses a divide-by-CE_DIV pixel clock-enable,
//  so no derived 25 MHz clock is needed. Feeds the pixel/colour stage: raster coordinates, data-enable
//  and sync. The colour stage registers its RGB on pix_ce and drives vga_r/g/b with hs/vs.
// PARAMETERS
//  CE_DIV    4    clk_100MHz cycles per pixel (>=2)
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels (H_TOTAL = sum = 800)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines (V_TOTAL = sum = 525)
//  SYNC_POL  0    asserted level of hs/vs (0 = active-low)
// PORTS
//  clk_100MHz   in   1   system clock
//  reset        in   1   asynchronous, active-high
//  pix_ce       out  1   one-clk pulse every CE_DIV clks; pixel advance strobe
//  x            out  10  horizontal counter, 0..H_TOTAL-1
//  y            out  10  vertical counter, 0..V_TOTAL-1
//  de           out  1   1 when x<H_ACTIVE && y<V_ACTIVE
//  hs           out  1   horizontal sync, level SYNC_POL when asserted
//  vs           out  1   vertical sync, level SYNC_POL when asserted
//  frame_start  out  1   one-clk pulse, coincident with pix_ce, on wrap to (0,0)
//  quad         out  2   (VGA_QUADRANT_EN only) screen quadrant of the current pixel
// BEHAVIOUR
//  - Reset: prescaler=0, x=0, y=0, pix_ce=0, de=0, frame_start=0, hs=vs=~SYNC_POL (deasserted).
//    Outputs are valid from the first pix_ce. Pixel (0,0) of frame 0 shows de=0.
//  - Prescaler counts 0..CE_DIV-1 and wraps. pix_ce is registered; it is high in the clk
//    after prescaler==CE_DIV-1. First pix_ce is the CE_DIV-th rising edge after reset release.
//  - On each edge where the prescaler wraps:
//    - x <= (x==H_TOTAL-1) ? 0 : x+1.
//    - On x wrap: y <= (y==V_TOTAL-1) ? 0 : y+1.
//    - x/y do not change at any other time.
//  - de, hs, vs and quad are registered from the NEXT x/y values, so they are aligned with x/y
//    in the same cycle. Zero latency relative to the coordinates.
//  - hs is asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
//  - vs is asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491). vs is line-aligned:
//    it changes only in the cycle where x becomes 0.
//  - frame_start is high exactly when x and y both become 0. This is 1 clk, the same clk as pix_ce.
//  - Counter widths: 10 bits. Compare against localparams. No arithmetic overflow is possible:
//    both counters wrap before 1023.
//  - A reset pulse mid-frame returns everything to the reset state immediately (async).
//    Counting resumes from (0,0) with no partial-line artefact.
//  - No inputs other than clock and reset. The block is free-running.
// CONFIGURATION
//  VGA_QUADRANT_EN defined:
//    - quad port exists, registered and aligned with x/y.
//    - quad = {y>=V_ACTIVE/2, x>=H_ACTIVE/2} when de=1, else 2'b00. Reset value 2'b00.
//    - Drives the switch-selected quadrant colour mux in the colour stage.
//  VGA_QUADRANT_EN undefined:
//    - quad port and its logic are absent.
//    - The colour stage decodes quadrants itself.
// TESTING
//  1. Release reset at t0 -> first pix_ce after 4 clks, then every 4 clks. x=1,y=0 after the first pix_ce.
//  2. Count clks across one line -> 3200 clks between x==0 events. hs asserted for 96 pix_ce = 384 clks,
//     starting when x becomes 656.
//  3. Run 1 full frame -> frame_start period 1,680,000 clks. de high for exactly 307,200 pix_ce.
//     vs asserted for 2 lines = 1600 pix_ce, starting at y=490,x=0.
//  4. Boundaries -> at x=639/640 de falls. At x=799 the next x is 0 and y increments.
//     At (799,524) the next state is (0,0) with frame_start=1.
//  5. Assert reset for 3 clks at x=300,y=200 -> outputs at reset values during reset.
//     After release, the timing of scenario 1 repeats.
//  6. VGA_QUADRANT_EN: at (100,100) quad=0. (400,100)=1. (100,300)=2. (639,479)=3.
//     At (700,100) quad=0 (de=0).

Source files
------------

// File: rtl/vga_timing_ce_if.sv
// Timing bundle from the VGA timing generator to the pixel/colour stage.
// Optional member: quad, present only when VGA_QUADRANT_EN is defined.
interface vga_timing_ce_if;
    logic       pix_ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       frame_start;
`ifdef VGA_QUADRANT_EN
    logic [1:0] quad;
`endif

`ifdef VGA_QUADRANT_EN
    modport master (output pix_ce, x, y, de, hs, vs, frame_start, quad);
    modport slave  (input  pix_ce, x, y, de, hs, vs, frame_start, quad);
`else
    modport master (output pix_ce, x, y, de, hs, vs, frame_start);
    modport slave  (input  pix_ce, x, y, de, hs, vs, frame_start);
`endif
endinterface

// File: rtl/vga_timing_ce.sv
// 640x480@60 VGA timing generator on the 100 MHz system clock with a
// divide-by-CE_DIV pixel clock-enable. Raster coordinates, data-enable,
// sync and frame strobe are all registered and change together on pix_ce.
// Optional feature macro: VGA_QUADRANT_EN (adds the registered quad output).
module vga_timing_ce #(
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic            clk_100MHz,
    input  logic            reset,
    vga_timing_ce_if.master tim
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

    localparam logic [PW-1:0] PS_LAST  = PW'(CE_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_QUADRANT_EN
    localparam logic [9:0]    H_HALF   = 10'(H_ACTIVE / 2);
    localparam logic [9:0]    V_HALF   = 10'(V_ACTIVE / 2);
`endif

    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          pix_ce_q, pix_ce_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fs_q, fs_d;
    logic          wrap;
`ifdef VGA_QUADRANT_EN
    logic [1:0]    quad_q, quad_d;
`endif

    // Next-state: prescaler, raster counters and the outputs derived from
    // the next coordinates so they line up with x/y in the same cycle.
    always_comb begin
        wrap     = (presc_q == PS_LAST);
        presc_d  = wrap ? '0 : presc_q + 1'b1;
        pix_ce_d = wrap;
        x_d      = x_q;
        y_d      = y_q;
        de_d     = de_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        fs_d     = 1'b0;
`ifdef VGA_QUADRANT_EN
        quad_d   = quad_q;
`endif
        if (wrap) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end

            de_d = (x_d < H_ACT) && (y_d < V_ACT);
            hs_d = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
            // vs only moves at line start so it never glitches mid-line
            if (x_d == 10'd0) begin
                vs_d = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
            end
            fs_d = (x_d == 10'd0) && (y_d == 10'd0);
`ifdef VGA_QUADRANT_EN
            quad_d = ((x_d < H_ACT) && (y_d < V_ACT)) ?
                     {(y_d >= V_HALF), (x_d >= H_HALF)} : 2'b00;
`endif
        end
    end

    // State registers; async reset returns the raster to (0,0) with syncs idle.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            pix_ce_q <= 1'b0;
            de_q     <= 1'b0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            fs_q     <= 1'b0;
`ifdef VGA_QUADRANT_EN
            quad_q   <= 2'b00;
`endif
        end else begin
            presc_q  <= presc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pix_ce_q <= pix_ce_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
`ifdef VGA_QUADRANT_EN
            quad_q   <= quad_d;
`endif
        end
    end

    assign tim.pix_ce      = pix_ce_q;
    assign tim.x           = x_q;
    assign tim.y           = y_q;
    assign tim.de          = de_q;
    assign tim.hs          = hs_q;
    assign tim.vs          = vs_q;
    assign tim.frame_start = fs_q;
`ifdef VGA_QUADRANT_EN
    assign tim.quad        = quad_q;
`endif

endmodule
